// File: rtl/apb_master_if.sv
// apb_master_if: request/response port and APB bus signals of apb_master
// Signals:
//   cmd_valid/cmd_ready/cmd_write/cmd_addr/cmd_wdata  request handshake and command fields
//   rsp_valid/rsp_rdata/rsp_err                       one-cycle completion strobe and result
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA                  APB outputs of the master
//   PREADY/PRDATA                                     APB inputs from the target
// Modports: master (the apb_master side), slave (the requester/target side)
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PREADY, PRDATA,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_master.sv
// apb_master: single-owner APB requester running one SETUP/ACCESS transfer per accepted command
// Ports:
//   pclk  in  bus clock, rising edge
//   prst  in  asynchronous active-high reset
//   bus   apb_master_if.master: cmd_* request, rsp_* completion strobe, APB PSEL..PRDATA
// Optional feature: define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait states
// (rsp_err=1); otherwise ACCESS waits for PREADY indefinitely and rsp_err is tied 0.
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic         pclk,
  input  logic         prst,
  apb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t            r_state;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic              r_rsp_valid;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end
`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  // the edge that would take the count to TIMEOUT_CYCLES is the aborting edge
  localparam logic [CW-1:0] LIM = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_abort;
  assign w_abort     = !bus.PREADY && (r_cnt == LIM);
  assign bus.rsp_err = r_err;
`else
  assign bus.rsp_err = 1'b0;
`endif
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      r_state     <= IDLE;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
`ifdef APB_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      r_rsp_valid <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_err       <= 1'b0;
`endif
      case (r_state)
        IDLE: if (bus.cmd_valid) begin
          r_pwrite  <= bus.cmd_write;
          r_paddr   <= bus.cmd_addr;
          r_pwdata  <= bus.cmd_write ? bus.cmd_wdata : '0;
          r_psel    <= 1'b1;
          r_penable <= 1'b0;
          r_state   <= SETUP;
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        ACCESS: if (bus.PREADY) begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_rdata     <= r_pwrite ? '0 : bus.PRDATA;
          r_state     <= IDLE;
        end
`ifdef APB_TIMEOUT_EN
        else if (w_abort) begin
          r_psel      <= 1'b0;
          r_penable   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_err       <= 1'b1;
          r_rdata     <= '0;
          r_state     <= IDLE;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rdata;
  assign bus.PSEL      = r_psel;
  assign bus.PENABLE   = r_penable;
  assign bus.PWRITE    = r_pwrite;
  assign bus.PADDR     = r_paddr;
  assign bus.PWDATA    = r_pwdata;
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: directed scoreboard bench for apb_master against a 16-register APB target model
module tb_apb_master;
  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (.pclk(pclk), .prst(prst), .bus(bus));

  typedef struct packed {logic [31:0] rdata; logic err;} exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int psel_cyc = 0;
  int pen_cyc = 0;
  int psel_rise = 0;
  int rsp_cnt = 0;
  int n_acc = 0;

  logic [31:0] mem [16];
  int   waits = 0;
  logic stall = 1'b0;
  int   wc = 0;

  assign bus.PREADY = bus.PSEL && bus.PENABLE && !stall && (wc >= waits);
  assign bus.PRDATA = (bus.PSEL && bus.PENABLE) ? mem[bus.PADDR[3:0]] : 32'h0BAD_F00D;

  always_ff @(posedge pclk) begin
    wc <= (bus.PSEL && bus.PENABLE && !bus.PREADY) ? wc + 1 : 0;
    if (bus.PSEL && bus.PENABLE && bus.PREADY && bus.PWRITE) mem[bus.PADDR[3:0]] <= bus.PWDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge pclk);
    if (bus.cmd_valid && bus.cmd_ready && !prst) n_acc++;
  end

  logic        prev_psel = 1'b0;
  logic        prev_pwrite = 1'b0;
  logic [31:0] prev_paddr = '0;
  logic [31:0] prev_pwdata = '0;
  exp_t        e;
  initial forever begin
    @(negedge pclk);
    if (bus.PSEL) psel_cyc++;
    if (bus.PENABLE) pen_cyc++;
    if (bus.PSEL && !prev_psel) psel_rise++;
    if (bus.PSEL && prev_psel) begin
      chk("paddr_stable", bus.PADDR, prev_paddr);
      chk("pwdata_stable", bus.PWDATA, prev_pwdata);
      chk("pwrite_stable", 32'(bus.PWRITE), 32'(prev_pwrite));
    end
    if (bus.PSEL) chk("ready_while_busy", 32'(bus.cmd_ready), 0);
    if (bus.rsp_valid) begin
      rsp_cnt++;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL rsp_unexpected: observed empty scoreboard required a pending entry");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_rdata", bus.rsp_rdata, e.rdata);
        chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
      end
    end
    prev_psel   = bus.PSEL;
    prev_pwrite = bus.PWRITE;
    prev_paddr  = bus.PADDR;
    prev_pwdata = bus.PWDATA;
  end

  task automatic issue(input logic w, input int a, input logic [31:0] d, input logic [31:0] er, input logic ee);
    int   k = 0;
    exp_t x;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    while (!bus.cmd_ready && k < 50) begin
      @(negedge pclk);
      k++;
    end
    n_checks++;
    assert (k < 50) else begin
      n_fail++;
      $error("FAIL accept_timeout: observed %0d cycles waiting required fewer than 50", k);
    end
    x.rdata = er;
    x.err   = ee;
    sb.push_back(x);
    @(negedge pclk);
  endtask

  task automatic wait_done();
    int k = 0;
    while (sb.size() != 0 && k < 200) begin
      @(negedge pclk);
      k++;
    end
    n_checks++;
    assert (k < 200) else begin
      n_fail++;
      $error("FAIL rsp_timeout: observed %0d pending responses required 0", sb.size());
    end
  endtask

  task automatic clear();
    psel_cyc = 0;
    pen_cyc = 0;
    psel_rise = 0;
    rsp_cnt = 0;
    n_acc = 0;
  endtask

  function automatic logic [31:0] dpat(input int i);
    return 32'hC0DE_0000 + i * 32'h0001_0101;
  endfunction

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    repeat (2) @(negedge pclk);
    chk("rst_psel", 32'(bus.PSEL), 0);
    chk("rst_penable", 32'(bus.PENABLE), 0);
    chk("rst_pwrite", 32'(bus.PWRITE), 0);
    chk("rst_paddr", bus.PADDR, 0);
    chk("rst_pwdata", bus.PWDATA, 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_rsp_err", 32'(bus.rsp_err), 0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
    prst = 1'b0;
    @(negedge pclk);

    // write, zero wait states, cycle-by-cycle latency
    clear();
    waits = 0;
    issue(1'b1, 3, 32'hDEAD_BEEF, 32'h0, 1'b0);
    bus.cmd_valid = 1'b0;
    chk("setup_psel", 32'(bus.PSEL), 1);
    chk("setup_penable", 32'(bus.PENABLE), 0);
    chk("setup_paddr", bus.PADDR, 3);
    chk("setup_cmd_ready", 32'(bus.cmd_ready), 0);
    @(negedge pclk);
    chk("access_penable", 32'(bus.PENABLE), 1);
    chk("access_pwdata", bus.PWDATA, 32'hDEAD_BEEF);
    @(negedge pclk);
    chk("wr_rsp_strobe", 32'(bus.rsp_valid), 1);
    chk("wr_done_psel", 32'(bus.PSEL), 0);
    wait_done();
    @(negedge pclk);
    chk("wr_rsp_one_cycle", 32'(bus.rsp_valid), 0);
    chk("wr_psel_cycles", psel_cyc, 2);
    chk("wr_penable_cycles", pen_cyc, 1);
    chk("wr_rsp_count", rsp_cnt, 1);
    chk("wr_slave_reg3", mem[3], 32'hDEAD_BEEF);

    // read with two wait states
    clear();
    waits = 2;
    issue(1'b0, 3, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0);
    bus.cmd_valid = 1'b0;
    chk("rd_pwdata_zero", bus.PWDATA, 0);
    chk("rd_pwrite", 32'(bus.PWRITE), 0);
    wait_done();
    chk("rd_psel_cycles", psel_cyc, 4);
    chk("rd_penable_cycles", pen_cyc, 3);
    chk("rd_rsp_count", rsp_cnt, 1);

    // back-to-back writes with cmd_valid held high
    clear();
    waits = 1;
    for (int i = 0; i < 4; i++) issue(1'b1, i, 32'h1000 + i, 32'h0, 1'b0);
    bus.cmd_valid = 1'b0;
    wait_done();
    chk("b2b_accepts", n_acc, 4);
    chk("b2b_rsp_count", rsp_cnt, 4);
    chk("b2b_psel_periods", psel_rise, 4);
    for (int i = 0; i < 4; i++) chk("b2b_slave_reg", mem[i], 32'h1000 + i);

    // reset in the middle of ACCESS
    clear();
    waits = 0;
    stall = 1'b1;
    issue(1'b0, 0, 32'h0, 32'h1000, 1'b0);
    bus.cmd_valid = 1'b0;
    @(negedge pclk);
    chk("mid_psel", 32'(bus.PSEL), 1);
    chk("mid_penable", 32'(bus.PENABLE), 1);
    #2 prst = 1'b1;
    #1;
    chk("arst_psel", 32'(bus.PSEL), 0);
    chk("arst_penable", 32'(bus.PENABLE), 0);
    chk("arst_cmd_ready", 32'(bus.cmd_ready), 1);
    sb.delete();
    repeat (2) @(negedge pclk);
    prst = 1'b0;
    stall = 1'b0;
    chk("arst_no_rsp", rsp_cnt, 0);
    issue(1'b0, 0, 32'h0, 32'h1000, 1'b0);
    bus.cmd_valid = 1'b0;
    wait_done();
    chk("arst_recover_rsp", rsp_cnt, 1);

`ifdef APB_TIMEOUT_EN
    // timeout abort after TIMEOUT_CYCLES ACCESS cycles
    clear();
    stall = 1'b1;
    issue(1'b0, 5, 32'h0, 32'h0, 1'b1);
    bus.cmd_valid = 1'b0;
    wait_done();
    stall = 1'b0;
    chk("to_penable_cycles", pen_cyc, 4);
    chk("to_psel_cycles", psel_cyc, 5);
    chk("to_rsp_count", rsp_cnt, 1);
`else
    // no timeout: still waiting after 100 cycles, then completes
    clear();
    stall = 1'b1;
    issue(1'b0, 2, 32'h0, 32'h1002, 1'b0);
    bus.cmd_valid = 1'b0;
    repeat (100) @(negedge pclk);
    chk("wait_psel", 32'(bus.PSEL), 1);
    chk("wait_penable", 32'(bus.PENABLE), 1);
    chk("wait_no_rsp", rsp_cnt, 0);
    stall = 1'b0;
    wait_done();
    chk("wait_rsp_count", rsp_cnt, 1);
`endif

    // full register sweep: write then read every address
    clear();
    for (int i = 0; i < 16; i++) begin
      waits = i % 3;
      issue(1'b1, i, dpat(i), 32'h0, 1'b0);
      bus.cmd_valid = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      waits = (i + 1) % 3;
      issue(1'b0, i, 32'h0, dpat(i), 1'b0);
      bus.cmd_valid = 1'b0;
    end
    wait_done();
    chk("sweep_rsp_count", rsp_cnt, 32);
    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
